mvau_wmem_seq: RTL and testbench

// - Address sequencer for one MVAU PE weight memory: single-port ROM, depth WMEM_DEPTH = SF*NF,

---
 rtl/mvau_wmem_seq.sv | 152 +++++++++++++++
 tb/tb_mvau_wmem_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mvau_wmem_seq.sv
// Address sequencer for one MVAU PE weight memory (1-cycle registered ROM read).
// Optional stall counter port enabled by defining MVAU_WMEM_SEQ_STALL_CNT_EN.
module mvau_wmem_seq #(
    parameter int SF           = 9,
    parameter int NF           = 4,
    parameter int NUM_PIX      = 16,
    parameter int WMEM_ADDR_BW = 6,
    parameter int PIX_BW       = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    output logic                    wt_v,
    input  logic                    wt_rdy,
    output logic                    sf_last,
    output logic                    nf_last,
    output logic                    pix_last,
    output logic                    busy,
`ifdef MVAU_WMEM_SEQ_STALL_CNT_EN
    output logic                    done,
    output logic [31:0]             stall_cnt
`else
    output logic                    done
`endif
);

    localparam int DEPTH = SF * NF;
    localparam int SF_BW = (SF > 1) ? $clog2(SF) : 1;
    localparam int NF_BW = (NF > 1) ? $clog2(NF) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]              r_state;
    logic [WMEM_ADDR_BW-1:0] r_addr;
    logic [SF_BW-1:0]        r_sf;
    logic [NF_BW-1:0]        r_nf;
    logic [PIX_BW-1:0]       r_pix;
    logic                    r_done;

    logic                    w_run;
    logic                    w_fire;
    logic                    w_sf_end;
    logic                    w_nf_end;
    logic                    w_pix_end;
    logic                    w_final;
    logic [WMEM_ADDR_BW-1:0] w_addr_nxt;
    logic [WMEM_ADDR_BW-1:0] w_wmem_addr;

    assign w_run     = (r_state == S_RUN);
    assign w_fire    = w_run & wt_rdy;
    assign w_sf_end  = (r_sf == SF_BW'(SF - 1));
    assign w_nf_end  = (r_nf == NF_BW'(NF - 1));
    assign w_pix_end = (r_pix == PIX_BW'(NUM_PIX - 1));
    assign w_final   = w_sf_end & w_nf_end & w_pix_end;

    // Next read address; pixel boundaries wrap back to word 0 without a bubble
    always_comb begin
        w_addr_nxt = r_addr + WMEM_ADDR_BW'(1);
        if (r_addr == WMEM_ADDR_BW'(DEPTH - 1)) begin
            w_addr_nxt = '0;
        end else begin
            w_addr_nxt = r_addr + WMEM_ADDR_BW'(1);
        end
    end

    // Look ahead on fire so the ROM has the following word registered by the next cycle
    always_comb begin
        w_wmem_addr = r_addr;
        if (w_fire) begin
            w_wmem_addr = w_addr_nxt;
        end else begin
            w_wmem_addr = r_addr;
        end
    end

    // Control FSM, address and fold/pixel counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_sf    <= '0;
            r_nf    <= '0;
            r_pix   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_fire) begin
                        if (w_final) begin
                            r_state <= S_IDLE;
                            r_addr  <= '0;
                            r_sf    <= '0;
                            r_nf    <= '0;
                            r_pix   <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr <= w_addr_nxt;
                            r_sf   <= w_sf_end ? '0 : r_sf + SF_BW'(1);
                            if (w_sf_end) begin
                                r_nf <= w_nf_end ? '0 : r_nf + NF_BW'(1);
                            end
                            if (w_sf_end && w_nf_end) begin
                                r_pix <= r_pix + PIX_BW'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wmem_addr = w_wmem_addr;
    assign wt_v      = w_run;
    assign sf_last   = w_run & w_sf_end;
    assign nf_last   = w_run & w_nf_end;
    assign pix_last  = w_run & w_pix_end;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

`ifdef MVAU_WMEM_SEQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles where a valid word waits on the PE
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_stall_cnt <= 32'd0;
        end else if ((r_state == S_IDLE) && start) begin
            r_stall_cnt <= 32'd0;
        end else if (w_run && !wt_rdy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mvau_wmem_seq.sv
// Self-checking bench for mvau_wmem_seq: randomized handshake against a word-index reference model.
module tb_mvau_wmem_seq;

    localparam int SF      = 4;
    localparam int NF      = 2;
    localparam int NPIX    = 3;
    localparam int DEPTH   = SF * NF;
    localparam int NWORDS  = DEPTH * NPIX;

    logic       aclk;
    logic       aresetn;
    logic       start;
    logic       wt_rdy;
    logic [5:0] wmem_addr;
    logic [5:0] wmem_out;
    logic       wt_v, sf_last, nf_last, pix_last, busy, done;

    logic       s_start;
    logic       s_rdy;
    logic [0:0] s_addr;
    logic       s_wt_v, s_sf_last, s_nf_last, s_pix_last, s_busy, s_done;

`ifdef MVAU_WMEM_SEQ_STALL_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] s_stall_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    mvau_wmem_seq #(.SF(SF), .NF(NF), .NUM_PIX(NPIX), .WMEM_ADDR_BW(6), .PIX_BW(16)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .wmem_addr(wmem_addr),
        .wt_v(wt_v), .wt_rdy(wt_rdy), .sf_last(sf_last), .nf_last(nf_last),
        .pix_last(pix_last), .busy(busy),
`ifdef MVAU_WMEM_SEQ_STALL_CNT_EN
        .done(done), .stall_cnt(stall_cnt)
`else
        .done(done)
`endif
    );

    mvau_wmem_seq #(.SF(1), .NF(1), .NUM_PIX(1), .WMEM_ADDR_BW(1), .PIX_BW(1)) dut_one (
        .aclk(aclk), .aresetn(aresetn), .start(s_start), .wmem_addr(s_addr),
        .wt_v(s_wt_v), .wt_rdy(s_rdy), .sf_last(s_sf_last), .nf_last(s_nf_last),
        .pix_last(s_pix_last), .busy(s_busy),
`ifdef MVAU_WMEM_SEQ_STALL_CNT_EN
        .done(s_done), .stall_cnt(s_stall_cnt)
`else
        .done(s_done)
`endif
    );

    // Weight ROM model: word = address, one-cycle registered read
    always @(posedge aclk) wmem_out <= wmem_addr;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall on word 7, 3: start re-pulsed at word 10
    task automatic do_run(input int mode, input int abort_at);
        int k = 0;
        int cyc = 0;
        int hold = 0;
        int stalls = 0;
        logic r;
        @(negedge aclk); start = 1'b1; wt_rdy = 1'b1;
        @(negedge aclk); start = 1'b0;
        chk("prime_wt_v", wt_v, 0);
        chk("prime_busy", busy, 1);
        while (k < NWORDS && cyc < 1000) begin
            @(negedge aclk);
            cyc++;
            start = 1'b0;
            chk("wt_v", wt_v, 1);
            chk("busy", busy, 1);
            chk("done_run", done, 0);
            chk("data", wmem_out, k % DEPTH);
            chk("sf_last", sf_last, (k % SF) == SF - 1);
            chk("nf_last", nf_last, ((k / SF) % NF) == NF - 1);
            chk("pix_last", pix_last, (k / DEPTH) == NPIX - 1);
            if (k == abort_at) begin
                aresetn = 1'b0;
                #1;
                chk("rst_wt_v", wt_v, 0);
                chk("rst_busy", busy, 0);
                chk("rst_addr", wmem_addr, 0);
                repeat (3) @(negedge aclk);
                aresetn = 1'b1;
                repeat (5) @(negedge aclk);
                chk("post_rst_wt_v", wt_v, 0);
                chk("post_rst_busy", busy, 0);
`ifdef MVAU_WMEM_SEQ_STALL_CNT_EN
                chk("post_rst_stall_cnt", stall_cnt, 0);
`endif
                return;
            end
            case (mode)
                1: r = 1'($urandom_range(0, 1));
                2: begin
                    if (k == 7 && hold < 5) begin r = 1'b0; hold++; end
                    else r = 1'b1;
                end
                3: begin
                    r = 1'b1;
                    if (k == 10) start = 1'b1;
                end
                default: r = 1'b1;
            endcase
            wt_rdy = r;
            #1;
            chk("addr", wmem_addr, (r ? k + 1 : k) % DEPTH);
            if (r) k++;
            else stalls++;
        end
        if (cyc >= 1000) chk("timeout", 0, 1);
        @(negedge aclk);
        chk("done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_wt_v", wt_v, 0);
        chk("end_addr", wmem_addr, 0);
        chk("end_pix_last", pix_last, 0);
        @(negedge aclk);
        chk("done_pulse", done, 0);
`ifdef MVAU_WMEM_SEQ_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, stalls);
`endif
    endtask

    initial begin
        aresetn = 1'b0;
        start   = 1'b0;
        wt_rdy  = 1'b0;
        s_start = 1'b0;
        s_rdy   = 1'b1;
        #12;
        chk("reset_wt_v", wt_v, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_addr", wmem_addr, 0);
        chk("reset_lasts", {sf_last, nf_last, pix_last}, 0);
        @(negedge aclk); aresetn = 1'b1;
        @(negedge aclk);
        chk("idle_wt_v", wt_v, 0);

        do_run(0, -1);
        do_run(1, -1);
        do_run(2, -1);
        do_run(3, -1);
        do_run(0, -1);
        do_run(1, 13);
        do_run(0, -1);
        do_run(1, -1);

        // Degenerate single-word configuration
        @(negedge aclk); s_start = 1'b1;
        @(negedge aclk); s_start = 1'b0;
        chk("one_prime_wt_v", s_wt_v, 0);
        chk("one_prime_busy", s_busy, 1);
        @(negedge aclk);
        chk("one_wt_v", s_wt_v, 1);
        chk("one_lasts", {s_sf_last, s_nf_last, s_pix_last}, 3'b111);
        chk("one_addr", s_addr, 0);
        @(negedge aclk);
        chk("one_end_wt_v", s_wt_v, 0);
        chk("one_done", s_done, 1);
        chk("one_end_busy", s_busy, 0);
        @(negedge aclk);
        chk("one_done_pulse", s_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
